// File: rtl/resolution_overlay_pkg.sv
// Shared types for the resolution-label overlay: ROM row width, video mode ids,
// and the char-ROM reader state encoding reused by other overlay readers.
package resolution_overlay_pkg;

  localparam int RESLINE_SIZE = 32;

  typedef struct packed {
    logic [3:0] id;
  } VideoMode;

  localparam logic [3:0] MODE_1080p = 4'd0;
  localparam logic [3:0] MODE_720p  = 4'd1;
  localparam logic [3:0] MODE_480p  = 4'd2;
  localparam logic [3:0] MODE_480i  = 4'd3;
  localparam logic [3:0] MODE_576p  = 4'd4;
  localparam logic [3:0] MODE_576i  = 4'd5;
  localparam logic [3:0] MODE_240p  = 4'd6;
  localparam logic [3:0] MODE_1080i = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHIFT = 2'd3
  } overlay_state_t;

endpackage

// File: rtl/resolution_overlay_if.sv
// Timing/ROM/mixer-facing signals of the resolution overlay.
interface resolution_overlay_if;
  import resolution_overlay_pkg::*;

  VideoMode                  videoMode;
  logic [11:0]               counterX;
  logic [11:0]               counterY;
  logic [3:0]                addr;
  logic [RESLINE_SIZE-1:0]   q;
  logic                      overlay;
  logic                      overlay_active;

  modport master (
    output videoMode, counterX, counterY, q,
    input  addr, overlay, overlay_active
  );

  modport slave (
    input  videoMode, counterX, counterY, q,
    output addr, overlay, overlay_active
  );

endinterface

// File: rtl/resolution_overlay_shifter.sv
// Serialises one ROM row MSB first, holding each bit for SCALE pixels.
// The shift register is cleared whenever idle so its MSB doubles as the pixel output.
module resolution_overlay_shifter
  import resolution_overlay_pkg::*;
#(
  parameter int SCALE = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    abort,
  input  logic [RESLINE_SIZE-1:0] din,
  output logic                    pix,
  output logic                    active,
  output logic                    done
);

  localparam int BW = $clog2(RESLINE_SIZE);
  localparam logic [2:0]    PIX_LAST = 3'(SCALE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(RESLINE_SIZE - 1);

  logic [RESLINE_SIZE-1:0] shreg;
  logic [2:0]              pixcnt;
  logic [BW-1:0]           bitcnt;

  assign pix  = shreg[RESLINE_SIZE-1];
  assign done = active && (pixcnt == PIX_LAST) && (bitcnt == BIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      pixcnt <= '0;
      bitcnt <= '0;
      active <= 1'b0;
    end else if (abort || done) begin
      shreg  <= '0;
      pixcnt <= '0;
      bitcnt <= '0;
      active <= 1'b0;
    end else if (load) begin
      shreg  <= din;
      pixcnt <= '0;
      bitcnt <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (pixcnt == PIX_LAST) begin
        pixcnt <= '0;
        shreg  <= shreg << 1;
        bitcnt <= bitcnt + 1'b1;
      end else begin
        pixcnt <= pixcnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/resolution_overlay.sv
// Resolution-label overlay: sequences glyph rows per line, fetches each row from
// the char ROM three pixels ahead of X_POS and hands it to the shifter.
module resolution_overlay
  import resolution_overlay_pkg::*;
#(
  parameter int X_POS = 16,
  parameter int Y_POS = 16,
  parameter int SCALE = 2
) (
  input logic                 clock,
  input logic                 reset,
  resolution_overlay_if.slave bus
);

  localparam logic [11:0] X_FETCH  = 12'(X_POS - 3);
  localparam logic [11:0] Y_TOP    = 12'(Y_POS);
  localparam logic [11:0] Y_END    = 12'(Y_POS + 16 * SCALE);
  localparam logic [2:0]  REP_LAST = 3'(SCALE - 1);

  overlay_state_t state, state_nxt;
  logic [3:0] row;
  logic [2:0] rep;
  logic [3:0] mode_q;
  logic       blanked;
  logic       line_start, frame_start, win_line, adv_line, mode_chg;
  logic       fetch, load, abort, done;

  assign line_start  = (bus.counterX == 12'd0);
  assign frame_start = line_start && (bus.counterY == 12'd0);
  assign win_line    = (bus.counterY >= Y_TOP) && (bus.counterY < Y_END);
  // Advance at the start of a line that continues the strip, so the last row sticks until frame start.
  assign adv_line    = (bus.counterY > Y_TOP) && (bus.counterY < Y_END);
  assign mode_chg    = (bus.videoMode.id != mode_q);

  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    load      = 1'b0;
    abort     = 1'b0;
    if (mode_chg || (line_start && state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      abort     = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: if (win_line && !blanked && bus.counterX == X_FETCH) begin
          fetch     = 1'b1;
          state_nxt = ST_FETCH;
        end
        ST_FETCH: state_nxt = ST_WAIT;
        ST_WAIT: begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
        ST_SHIFT: if (done) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bus.addr <= 4'd0;
    end else begin
      state <= state_nxt;
      if (fetch) bus.addr <= row;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row     <= 4'd0;
      rep     <= 3'd0;
      mode_q  <= 4'd0;
      blanked <= 1'b1;
    end else begin
      mode_q <= bus.videoMode.id;
      if (frame_start) begin
        row <= 4'd0;
        rep <= 3'd0;
      end else if (line_start && adv_line) begin
        if (rep == REP_LAST) begin
          rep <= 3'd0;
          row <= row + 4'd1;
        end else begin
          rep <= rep + 3'd1;
        end
      end
      // A label change mid-frame would mix glyphs, so stay dark until the next frame.
      if (mode_chg)         blanked <= 1'b1;
      else if (frame_start) blanked <= 1'b0;
    end
  end

  resolution_overlay_shifter #(.SCALE(SCALE)) u_shifter (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .abort  (abort),
    .din    (bus.q),
    .pix    (bus.overlay),
    .active (bus.overlay_active),
    .done   (done)
  );

endmodule

// File: tb/tb_resolution_overlay.sv
// Randomized frame/line stimulus with a scoreboard: expected pixels come from the
// glyph-position arithmetic (row = (y-Y_POS)/S, bit = (x-X_POS)/S) over the ROM image.
module tb_resolution_overlay;
  import resolution_overlay_pkg::*;

  localparam int X_POS = 16;
  localparam int Y_POS = 16;
  localparam int S     = 2;
  localparam int H_TOT = 88;
  localparam int V_TOT = 52;
  localparam int NF    = 8;

  typedef struct {
    logic       pix;
    logic       act;
    logic [3:0] addr;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  resolution_overlay_if bus ();

  resolution_overlay #(.X_POS(X_POS), .Y_POS(Y_POS), .SCALE(S)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [RESLINE_SIZE-1:0] rom [16][16];
  always @(posedge clock) bus.q <= rom[bus.videoMode.id][bus.addr];

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  int         cur_x, cur_y;
  logic [3:0] cur_id;
  logic       cur_r;
  bit         m_armed, m_fetched;
  int         m_frow;
  logic [3:0] m_fid, m_prev, m_addr;

  // Advance the reference by one clock edge using the inputs held across it.
  task automatic model_step(output exp_t e);
    bit chg;
    int idx;
    e = '{pix: 1'b0, act: 1'b0, addr: 4'd0};
    if (cur_r) begin
      m_armed = 0; m_fetched = 0; m_prev = 4'd0; m_addr = 4'd0;
      return;
    end
    chg    = (cur_id != m_prev);
    m_prev = cur_id;
    if (chg) begin m_armed = 0; m_fetched = 0; end
    if (cur_x == 0) m_fetched = 0;
    if (cur_x == 0 && cur_y == 0 && !chg) m_armed = 1;
    if (m_armed && !chg && cur_x == X_POS - 3 &&
        cur_y >= Y_POS && cur_y < Y_POS + 16 * S) begin
      m_fetched = 1;
      m_frow    = (cur_y - Y_POS) / S;
      m_fid     = cur_id;
      m_addr    = 4'(m_frow);
    end
    idx = cur_x + 1 - X_POS;
    if (m_fetched && idx >= 0 && idx < RESLINE_SIZE * S) begin
      e.act = 1'b1;
      e.pix = rom[m_fid][m_frow][RESLINE_SIZE - 1 - idx / S];
    end
    e.addr = m_addr;
  endtask

  task automatic cycle(input int x, input int y, input logic [3:0] id, input logic r);
    exp_t e;
    @(posedge clock);
    #1;
    model_step(e);
    if (r) begin
      e = '{pix: 1'b0, act: 1'b0, addr: 4'd0};
      m_armed = 0; m_fetched = 0; m_prev = 4'd0; m_addr = 4'd0;
    end
    sbq.push_back(e);
    cur_x = x; cur_y = y; cur_id = id; cur_r = r;
    bus.counterX    = 12'(x);
    bus.counterY    = 12'(y);
    bus.videoMode.id = id;
    reset           = r;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      total += 3;
      if (bus.overlay !== e.pix) begin
        bad++;
        $display("FAIL overlay x=%0d y=%0d got=%b want=%b", cur_x, cur_y, bus.overlay, e.pix);
      end
      if (bus.overlay_active !== e.act) begin
        bad++;
        $display("FAIL overlay_active x=%0d y=%0d got=%b want=%b", cur_x, cur_y, bus.overlay_active, e.act);
      end
      if (bus.addr !== e.addr) begin
        bad++;
        $display("FAIL addr x=%0d y=%0d got=%0d want=%0d", cur_x, cur_y, bus.addr, e.addr);
      end
    end
  end

  logic [3:0] modes [NF];

  initial begin
    int         len;
    logic [3:0] m;
    logic       r;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        rom[i][j] = $urandom;
    rom[MODE_1080p][0] = {1'b1, {(RESLINE_SIZE-1){1'b0}}};
    rom[MODE_1080p][3] = '1;
    modes[0] = MODE_1080p;
    modes[1] = MODE_720p;
    modes[2] = MODE_720p;
    modes[3] = MODE_480p;
    for (int i = 4; i < NF; i++) modes[i] = 4'($urandom_range(0, 7));

    reset = 1'b1;
    cur_x = 1; cur_y = V_TOT - 1; cur_id = MODE_1080p; cur_r = 1'b1;
    bus.counterX = 12'(cur_x);
    bus.counterY = 12'(cur_y);
    bus.videoMode.id = cur_id;
    m_armed = 0; m_fetched = 0; m_frow = 0; m_fid = 4'd0; m_prev = 4'd0; m_addr = 4'd0;

    cycle(1, V_TOT - 1, MODE_1080p, 1'b1);
    cycle(2, V_TOT - 1, MODE_1080p, 1'b1);
    cycle(3, V_TOT - 1, MODE_1080p, 1'b0);

    for (int f = 0; f < NF; f++) begin
      for (int y = 0; y < V_TOT; y++) begin
        len = H_TOT;
        if (f == 2 && y == 18) len = X_POS + 4;
        else if (f >= 5 && $urandom_range(0, 15) == 0) len = $urandom_range(4, H_TOT);
        for (int x = 0; x < len; x++) begin
          m = modes[f];
          if (f == 2 && y >= 25) m = MODE_480p;
          // Switch labels on the last clock of a frame so frame start sees a stable mode.
          if (f < NF - 1 && y == V_TOT - 1 && x == len - 1) m = modes[f + 1];
          r = (f == 4 && y == 20 && (x == X_POS + 5 || x == X_POS + 6));
          cycle(x, y, m, r);
        end
      end
    end

    @(posedge clock);
    @(negedge clock);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
